// File: rtl/tick_gen.sv
// tick_gen: programmable tick/slow_clk rate generator with run/pause and single-step.
// Key debouncer is present only when TICK_GEN_DEBOUNCE_EN is defined.
module tick_gen #(
  parameter int TICK_DIV  = 33554432,
  parameter int CNT_W     = 26,
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic run_sw,
  input  logic step_key,
  output logic tick,
  output logic slow_clk,
  output logic paused
);
  typedef enum logic {PAUSE, RUN} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  state_t state, state_d;
  logic run_m, run_s, key_m, key_s, key_db, key_db_q, step_p;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic wrap, tick_d;
  always_ff @(posedge clk)
    if (reset) begin
      run_m    <= 1'b0;
      run_s    <= 1'b0;
      key_m    <= 1'b1;
      key_s    <= 1'b1;
      key_db_q <= 1'b1;
      step_p   <= 1'b0;
      state    <= PAUSE;
      cnt      <= '0;
      tick     <= 1'b0;
      slow_clk <= 1'b0;
    end else begin
      run_m    <= run_sw;
      run_s    <= run_m;
      key_m    <= step_key;
      key_s    <= key_m;
      key_db_q <= key_db;
      step_p   <= key_db_q & ~key_db;
      state    <= state_d;
      cnt      <= cnt_d;
      tick     <= tick_d;
      slow_clk <= slow_clk ^ tick_d;
    end
  // the current state decides whether a step is honoured, even on the cycle it leaves PAUSE
  always_comb begin
    state_d = run_s ? RUN : PAUSE;
    wrap    = (state == RUN) && (cnt == LAST);
    cnt_d   = (state != RUN) ? cnt : wrap ? '0 : cnt + 1'b1;
    tick_d  = (state == RUN) ? wrap : step_p;
  end
  assign paused = (state == PAUSE);
`ifdef TICK_GEN_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt;
  always_ff @(posedge clk)
    if (reset) begin
      db_cnt <= '0;
      key_db <= 1'b1;
    end else if (key_s == key_db)
      db_cnt <= '0;
    else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      key_db <= key_s;
      db_cnt <= '0;
    end else
      db_cnt <= db_cnt + 1'b1;
`else
  logic db_unused;
  assign db_unused = ^DB_W;
  assign key_db    = key_s;
`endif
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: randomized bench for tick_gen checked every cycle against a behavioural model.
module tb_tick_gen;
  localparam int TD = 8;
  localparam int CW = 4;
  localparam int DB = 4;
`ifdef TICK_GEN_DEBOUNCE_EN
  localparam int STEP_LAT = DB + 4;
`else
  localparam int STEP_LAT = 4;
`endif
  logic clk = 1'b0, reset = 1'b1, run_sw = 1'b0, step_key = 1'b1;
  logic tick, slow_clk, paused;
  int n_checks = 0, n_fail = 0;

  tick_gen #(.TICK_DIV(TD), .CNT_W(CW), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .run_sw(run_sw), .step_key(step_key),
    .tick(tick), .slow_clk(slow_clk), .paused(paused)
  );

  always #5 clk = ~clk;

  // model: ticks are every TD-th run cycle since reset, or a press seen through the sync/debounce delays
  bit started = 1'b0;
  logic m_tick, m_slow, m_paused, rh1, rh2, kh1, ks, db, prev_db, f1, f2;
  int run_cnt;
`ifdef TICK_GEN_DEBOUNCE_EN
  logic hist [DB];
  logic diff;
`endif
  always @(posedge clk) begin
    if (reset) begin
      m_tick = 0; m_slow = 0; m_paused = 1; run_cnt = 0;
      rh1 = 0; rh2 = 0; kh1 = 1; ks = 1; db = 1; f1 = 0; f2 = 0;
`ifdef TICK_GEN_DEBOUNCE_EN
      foreach (hist[i]) hist[i] = 1;
`endif
      started = 1;
    end else begin
      m_tick = m_paused ? f2 : ((run_cnt + 1) % TD == 0);
      if (!m_paused) run_cnt++;
      m_slow = m_slow ^ m_tick;
      m_paused = !rh2; rh2 = rh1; rh1 = run_sw;
      prev_db = db;
`ifdef TICK_GEN_DEBOUNCE_EN
      diff = 1;
      foreach (hist[i]) if (hist[i] == db) diff = 0;
      if (diff) db = hist[0];
      ks = kh1; kh1 = step_key;
      for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ks;
`else
      ks = kh1; kh1 = step_key; db = ks;
`endif
      f2 = f1; f1 = prev_db & !db;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (started) begin
      check("tick", tick, m_tick);
      check("slow_clk", slow_clk, m_slow);
      check("paused", paused, m_paused);
    end

  task automatic wait_tick(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!tick && n < 64);
  endtask

  task automatic count_ticks(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin @(negedge clk); if (tick) n++; end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_tick", tick, 1'b0);
    check("rst_slow", slow_clk, 1'b0);
    check("rst_paused", paused, 1'b1);
    reset = 0;
    count_ticks(50, n);
    check_int("idle_ticks", n, 0);
    check("idle_paused", paused, 1'b1);
    run_sw = 1; n = 0;
    do begin @(negedge clk); n++; end while (paused && n < 20);
    check_int("run_latency", n, 3);
    wait_tick(n);
    check_int("first_tick", n, TD);
    wait_tick(n);
    check_int("period", n, TD);
    check("slow_after_two", slow_clk, 1'b0);
    repeat (2) @(negedge clk);
    run_sw = 0;
    count_ticks(20, n);
    check_int("paused_ticks", n, 0);
    run_sw = 1;
    wait_tick(n);
    check_int("resume_tick", n, 6);
    run_sw = 0;
    repeat (6) @(negedge clk);
`ifdef TICK_GEN_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) begin
      step_key = 0; repeat (2) @(negedge clk);
      step_key = 1; repeat (2) @(negedge clk);
    end
`endif
    step_key = 0;
    wait_tick(n);
    check_int("step_latency", n, STEP_LAT);
    count_ticks(10, n);
    check_int("hold_ticks", n, 0);
    step_key = 1;
    count_ticks(20, n);
    check_int("release_ticks", n, 0);
    run_sw = 1;
    repeat (12) @(negedge clk);
    step_key = 0;
    repeat (15) @(negedge clk);
    step_key = 1;
    n = 0;
    while (!(!m_paused && run_cnt % TD == TD - 1) && n < 40) begin @(negedge clk); n++; end
    check_int("reach_last", (n < 40) ? 1 : 0, 1);
    reset = 1;
    @(negedge clk);
    check("rst7_tick", tick, 1'b0);
    check("rst7_slow", slow_clk, 1'b0);
    check("rst7_paused", paused, 1'b1);
    reset = 0;
    repeat (3000) begin
      @(negedge clk);
      if ($urandom % 50 == 0) run_sw = ~run_sw;
      if ($urandom % 8 == 0) step_key = ~step_key;
      reset = ($urandom % 700 == 0);
    end
    reset = 0;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
